// File: rtl/lsu_pkg.sv
// Shared LSU types: operation codes, access sizes, FSM states and opcode helpers.
// Consumed by the LSU, its formatter and the decoder.
package lsu_pkg;

  localparam int CPU_WIDTH     = 64;
  localparam int LSU_OPT_WIDTH = 4;

  typedef logic [LSU_OPT_WIDTH-1:0] lsu_opt_t;

  localparam lsu_opt_t LSU_NOP = 4'd0;
  localparam lsu_opt_t LSU_LB  = 4'd1;
  localparam lsu_opt_t LSU_LH  = 4'd2;
  localparam lsu_opt_t LSU_LW  = 4'd3;
  localparam lsu_opt_t LSU_LD  = 4'd4;
  localparam lsu_opt_t LSU_LBU = 4'd5;
  localparam lsu_opt_t LSU_LHU = 4'd6;
  localparam lsu_opt_t LSU_LWU = 4'd7;
  localparam lsu_opt_t LSU_SB  = 4'd8;
  localparam lsu_opt_t LSU_SH  = 4'd9;
  localparam lsu_opt_t LSU_SW  = 4'd10;
  localparam lsu_opt_t LSU_SD  = 4'd11;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  function automatic lsu_size_e lsu_size(input lsu_opt_t opt);
    case (opt)
      LSU_LB, LSU_LBU, LSU_SB: lsu_size = SZ_B;
      LSU_LH, LSU_LHU, LSU_SH: lsu_size = SZ_H;
      LSU_LW, LSU_LWU, LSU_SW: lsu_size = SZ_W;
      default:                 lsu_size = SZ_D;
    endcase
  endfunction

  function automatic logic lsu_is_load(input lsu_opt_t opt);
    lsu_is_load = (opt >= LSU_LB) && (opt <= LSU_LWU);
  endfunction

  function automatic logic lsu_is_store(input lsu_opt_t opt);
    lsu_is_store = (opt >= LSU_SB) && (opt <= LSU_SD);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Upstream, downstream and memory handshake bundle of the LSU.
// slave is the LSU side; master is the surrounding pipeline/memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  lsu_opt_t             i_lsu_opt;
  logic [CPU_WIDTH-1:0] i_addr;
  logic [CPU_WIDTH-1:0] i_wdata;

  logic                 o_valid;
  logic                 i_ready;
  logic [CPU_WIDTH-1:0] o_res;
  logic                 o_misalign;

  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic [CPU_WIDTH-1:0] o_mem_wdata;
  logic [7:0]           o_mem_wmask;
  logic                 i_mem_gnt;
  logic                 i_mem_rvalid;
  logic [CPU_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_lsu_opt, i_addr, i_wdata, i_ready,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_valid, o_res, o_misalign,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
  );

  modport master (
    output i_valid, i_lsu_opt, i_addr, i_wdata, i_ready,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_valid, o_res, o_misalign,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
  );

endinterface

// File: rtl/lsu_fmt.sv
// Combinational LSU datapath: alignment check, store lane shift/mask, load extract/extend.
// Zero latency, no state, no backpressure.
module lsu_fmt
  import lsu_pkg::*;
(
  input  lsu_opt_t             req_opt,
  input  logic [2:0]           req_off,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  output logic                 req_misalign,
  output logic [CPU_WIDTH-1:0] st_wdata,
  output logic [7:0]           st_wmask,
  input  lsu_opt_t             ld_opt,
  input  logic [2:0]           ld_off,
  input  logic [CPU_WIDTH-1:0] ld_rdata,
  output logic [CPU_WIDTH-1:0] ld_res
);

  logic [CPU_WIDTH-1:0] ld_shift;

  always_comb begin
    req_misalign = 1'b0;
    if (lsu_is_load(req_opt) || lsu_is_store(req_opt)) begin
      case (lsu_size(req_opt))
        SZ_H:    req_misalign = req_off[0];
        SZ_W:    req_misalign = |req_off[1:0];
        SZ_D:    req_misalign = |req_off;
        default: req_misalign = 1'b0;
      endcase
    end

    st_wdata = req_wdata << {req_off, 3'b000};
    case (lsu_size(req_opt))
      SZ_B:    st_wmask = 8'h01 << req_off;
      SZ_H:    st_wmask = 8'h03 << req_off;
      SZ_W:    st_wmask = 8'h0F << req_off;
      default: st_wmask = 8'hFF;
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    case (ld_opt)
      LSU_LB:  ld_res = {{(CPU_WIDTH-8){ld_shift[7]}},   ld_shift[7:0]};
      LSU_LH:  ld_res = {{(CPU_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
      LSU_LW:  ld_res = {{(CPU_WIDTH-32){ld_shift[31]}}, ld_shift[31:0]};
      LSU_LD:  ld_res = ld_shift;
      LSU_LBU: ld_res = {{(CPU_WIDTH-8){1'b0}},  ld_shift[7:0]};
      LSU_LHU: ld_res = {{(CPU_WIDTH-16){1'b0}}, ld_shift[15:0]};
      LSU_LWU: ld_res = {{(CPU_WIDTH-32){1'b0}}, ld_shift[31:0]};
      default: ld_res = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned doubleword memory transaction per accepted instruction.
// Latency 1 (NOP/misaligned) to 2+ cycles (memory); one op in flight, o_ready only in IDLE.
module lsu
  import lsu_pkg::*;
(
  input logic  i_clk,
  input logic  i_rst,
  lsu_if.slave bus
);

  lsu_state_e           state_q, state_d;
  lsu_opt_t             opt_q, opt_d;
  logic [2:0]           off_q, off_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [CPU_WIDTH-1:0] res_q, res_d;
  logic                 misalign_q, misalign_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [CPU_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CPU_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]           mem_wmask_q, mem_wmask_d;

  logic                 req_misalign;
  logic                 req_is_store;
  logic                 req_is_mem;
  logic [CPU_WIDTH-1:0] st_wdata;
  logic [7:0]           st_wmask;
  logic [CPU_WIDTH-1:0] ld_res;

  lsu_fmt u_fmt (
    .req_opt      (bus.i_lsu_opt),
    .req_off      (bus.i_addr[2:0]),
    .req_wdata    (bus.i_wdata),
    .req_misalign (req_misalign),
    .st_wdata     (st_wdata),
    .st_wmask     (st_wmask),
    .ld_opt       (opt_q),
    .ld_off       (off_q),
    .ld_rdata     (bus.i_mem_rdata),
    .ld_res       (ld_res)
  );

  assign req_is_store = lsu_is_store(bus.i_lsu_opt);
  assign req_is_mem   = req_is_store || lsu_is_load(bus.i_lsu_opt);

  always_comb begin
    state_d     = state_q;
    opt_d       = opt_q;
    off_d       = off_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    res_d       = res_q;
    misalign_d  = misalign_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          opt_d   = bus.i_lsu_opt;
          off_d   = bus.i_addr[2:0];
          ready_d = 1'b0;
          if (req_misalign || !req_is_mem) begin
            state_d    = ST_RESP;
            valid_d    = 1'b1;
            misalign_d = req_misalign;
            res_d      = req_misalign ? '0 : bus.i_addr;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {bus.i_addr[CPU_WIDTH-1:3], 3'b000};
            mem_wdata_d = req_is_store ? st_wdata : '0;
            mem_wmask_d = req_is_store ? st_wmask : 8'h00;
          end
        end
      end
      ST_REQ: begin
        // rvalid before the grant belongs to nobody and is dropped
        if (bus.i_mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_wmask_d = 8'h00;
          if (mem_we_q) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            res_d   = '0;
          end else if (bus.i_mem_rvalid) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            res_d   = ld_res;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          res_d   = ld_res;
        end
      end
      ST_RESP: begin
        if (bus.i_ready) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b0;
          ready_d    = 1'b1;
          res_d      = '0;
          misalign_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      opt_q       <= LSU_NOP;
      off_q       <= 3'd0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      res_q       <= '0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      opt_q       <= opt_d;
      off_q       <= off_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      res_q       <= res_d;
      misalign_q  <= misalign_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_res       = res_q;
  assign bus.o_misalign  = misalign_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: driver issues ops and plays memory, monitor scores responses.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if bus();

  lsu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},     64'(bus.o_ready),    64'd1);
    chk({tag, "_valid"},     64'(bus.o_valid),    64'd0);
    chk({tag, "_misalign"},  64'(bus.o_misalign), 64'd0);
    chk({tag, "_res"},       bus.o_res,           64'd0);
    chk({tag, "_mem_req"},   64'(bus.o_mem_req),  64'd0);
    chk({tag, "_mem_we"},    64'(bus.o_mem_we),   64'd0);
    chk({tag, "_mem_addr"},  bus.o_mem_addr,      64'd0);
    chk({tag, "_mem_wdata"}, bus.o_mem_wdata,     64'd0);
    chk({tag, "_mem_wmask"}, 64'(bus.o_mem_wmask), 64'd0);
  endtask

  // Monitor: every cycle o_valid is up, the presented result must match the head entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.o_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: actual o_valid=1 required o_valid=0 res=%h", bus.o_res);
        end else begin
          chk("resp_res", bus.o_res, sb_q[0].res);
          chk("resp_misalign", 64'(bus.o_misalign), 64'(sb_q[0].mis));
          if (bus.i_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic run_txn(input string tag, input lsu_opt_t opt,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [63:0] exp_maddr, input logic [63:0] exp_mwdata,
                         input logic [7:0] exp_mask, input logic [63:0] exp_res, input logic exp_mis,
                         input int gnt_dly, input int rv_dly, input int exp_vcyc, input int stall);
    int   cyc;
    int   gnt_cyc;
    int   stall_left;
    bit   granted, rv_done, seen_valid, done;
    logic is_st, is_ld, exp_req;
    is_st   = (opt >= LSU_SB) && (opt <= LSU_SD);
    is_ld   = (opt >= LSU_LB) && (opt <= LSU_LWU);
    exp_req = (is_st || is_ld) && !exp_mis;

    chk({tag, "_accept_ready"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid   = 1'b1;
    bus.i_lsu_opt = opt;
    bus.i_addr    = addr;
    bus.i_wdata   = wdata;
    sb_q.push_back('{res: exp_res, mis: exp_mis});
    @(posedge clk); #1;
    bus.i_valid   = 1'b0;
    bus.i_lsu_opt = 4'hF;
    bus.i_addr    = ~addr;
    bus.i_wdata   = ~wdata;

    cyc = 1; gnt_cyc = 0; granted = 0; rv_done = 0; seen_valid = 0; done = 0;
    stall_left = stall;
    while (!done && cyc <= 40) begin
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      if (exp_req && !granted) begin
        chk({tag, "_mem_req"},   64'(bus.o_mem_req),   64'd1);
        chk({tag, "_mem_addr"},  bus.o_mem_addr,       exp_maddr);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata,      exp_mwdata);
        chk({tag, "_mem_wmask"}, 64'(bus.o_mem_wmask), 64'(exp_mask));
        chk({tag, "_mem_we"},    64'(bus.o_mem_we),    64'(is_st));
        if (cyc - 1 == gnt_dly) begin
          bus.i_mem_gnt = 1'b1;
          granted       = 1;
          gnt_cyc       = cyc;
        end else if (cyc == 1) begin
          bus.i_mem_rvalid = 1'b1;
        end
      end else begin
        chk({tag, "_no_mem_req"}, 64'(bus.o_mem_req), 64'd0);
      end
      if (granted && is_ld && !rv_done && cyc == gnt_cyc + rv_dly) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rdata;
        rv_done          = 1;
      end
      if (bus.o_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          chk({tag, "_latency"}, 64'(cyc), 64'(exp_vcyc));
        end
        if (stall_left > 0) begin
          bus.i_ready = 1'b0;
          stall_left--;
        end else begin
          bus.i_ready = 1'b1;
          done        = 1;
        end
      end else begin
        bus.i_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_ready      = 1'b1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual no response required response by cycle %0d", tag, exp_vcyc);
    end else begin
      chk({tag, "_after_ready"}, 64'(bus.o_ready), 64'd1);
      chk({tag, "_after_valid"}, 64'(bus.o_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_lsu_opt    = LSU_NOP;
    bus.i_addr       = '0;
    bus.i_wdata      = '0;
    bus.i_ready      = 1'b1;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("nop",    LSU_NOP, 64'h1234, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00,
            64'h1234, 1'b0, 0, 0, 1, 0);
    run_txn("sb",     LSU_SB, 64'h1000_0005, 64'hAB, 64'h0, 64'h1000_0000,
            64'h0000_AB00_0000_0000, 8'h20, 64'h0, 1'b0, 0, 0, 2, 0);
    run_txn("lb",     LSU_LB, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 64'h2000, 64'h0, 8'h00,
            64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0, 1, 3, 0);
    run_txn("lbu",    LSU_LBU, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 64'h2000, 64'h0, 8'h00,
            64'h80, 1'b0, 0, 0, 2, 0);
    run_txn("lw_mis", LSU_LW, 64'h2002, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00,
            64'h0, 1'b1, 0, 0, 1, 0);
    run_txn("ld_slow", LSU_LD, 64'h3000_0008, 64'h5555, 64'h8877_6655_4433_2211, 64'h3000_0008,
            64'h0, 8'h00, 64'h8877_6655_4433_2211, 1'b0, 3, 2, 7, 2);
    run_txn("lh",     LSU_LH, 64'h4006, 64'h0, 64'hBEEF_0000_0000_0000, 64'h4000, 64'h0, 8'h00,
            64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 0, 1, 3, 0);
    run_txn("lhu",    LSU_LHU, 64'h4006, 64'h0, 64'hBEEF_0000_0000_0000, 64'h4000, 64'h0, 8'h00,
            64'h0000_0000_0000_BEEF, 1'b0, 0, 0, 2, 0);
    run_txn("lw",     LSU_LW, 64'h4004, 64'h0, 64'h8000_0001_0000_0000, 64'h4000, 64'h0, 8'h00,
            64'hFFFF_FFFF_8000_0001, 1'b0, 1, 0, 3, 0);
    run_txn("lwu",    LSU_LWU, 64'h4004, 64'h0, 64'h8000_0001_0000_0000, 64'h4000, 64'h0, 8'h00,
            64'h0000_0000_8000_0001, 1'b0, 0, 0, 2, 0);
    run_txn("sh",     LSU_SH, 64'h5002, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 64'h5000,
            64'hFFFF_FFFF_1234_0000, 8'h0C, 64'h0, 1'b0, 0, 0, 2, 0);
    run_txn("sw",     LSU_SW, 64'h5004, 64'h0000_0000_CAFE_F00D, 64'h0, 64'h5000,
            64'hCAFE_F00D_0000_0000, 8'hF0, 64'h0, 1'b0, 1, 0, 3, 1);
    run_txn("sd",     LSU_SD, 64'h5000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h5000,
            64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0, 0, 0, 2, 0);
    run_txn("sd_mis", LSU_SD, 64'h5001, 64'h77, 64'h0, 64'h0, 64'h0, 8'h00,
            64'h0, 1'b1, 0, 0, 1, 0);
    run_txn("lh_mis", LSU_LH, 64'h4001, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00,
            64'h0, 1'b1, 0, 0, 1, 0);
    run_txn("nop_e",  4'hE, 64'hFFFF_0000_0000_0007, 64'h99, 64'h0, 64'h0, 64'h0, 8'h00,
            64'hFFFF_0000_0000_0007, 1'b0, 0, 0, 1, 0);

    // Reset while the request is still waiting for a grant.
    bus.i_valid   = 1'b1;
    bus.i_lsu_opt = LSU_LD;
    bus.i_addr    = 64'h6000;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("rst_req_pre_mem_req", 64'(bus.o_mem_req), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("rst_req");

    // Reset in WAIT, followed by a late rvalid that must be ignored.
    bus.i_valid   = 1'b1;
    bus.i_lsu_opt = LSU_LD;
    bus.i_addr    = 64'h7000;
    @(posedge clk); #1;
    bus.i_valid   = 1'b0;
    bus.i_mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.i_mem_gnt = 1'b0;
    chk("rst_wait_pre_mem_req", 64'(bus.o_mem_req), 64'd0);
    chk("rst_wait_pre_ready",   64'(bus.o_ready),   64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("rst_wait");
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_valid", 64'(bus.o_valid), 64'd0);
      chk("late_rvalid_ready", 64'(bus.o_ready), 64'd1);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
